// File: rtl/mul_seq_pkg.sv
// rtl/mul_seq_pkg.sv - shared op/state encodings and operand magnitude helper
package mul_seq_pkg;

  typedef enum logic [1:0] {
    OP_MUL    = 2'b00,
    OP_MULH   = 2'b01,
    OP_MULHSU = 2'b10,
    OP_MULHU  = 2'b11
  } mul_op_e;

  typedef enum logic [2:0] {
    ST_DRAIN = 3'd0,
    ST_IDLE  = 3'd1,
    ST_ISSUE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_FIX   = 3'd4,
    ST_DONE  = 3'd5
  } mul_state_e;

  // 0x80000000 negates to itself, which is the correct unsigned magnitude
  function automatic logic [31:0] abs32(input logic [31:0] x, input logic is_signed);
    return (is_signed && x[31]) ? (~x + 32'd1) : x;
  endfunction

endpackage

// File: rtl/mul_seq_if.sv
// rtl/mul_seq_if.sv - request/response bundle between caller and mul_seq
interface mul_seq_if;
  import mul_seq_pkg::*;

  logic        valid;
  mul_op_e     op;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] res;
  logic        ready;
  logic        busy;

  modport master (output valid, op, a, b, input res, ready, busy);
  modport slave  (input valid, op, a, b, output res, ready, busy);

endinterface

// File: rtl/mul_seq_mul32.sv
// rtl/mul_seq_mul32.sv - unsigned 32x32 shift-add multiplier, no reset, ready 33 cycles after valid
module mul32 (
  input  logic        clk,
  input  logic        valid,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] res,
  output logic        ready
);

  logic        run_q;
  logic [4:0]  cnt_q;
  logic [31:0] mcand_q;
  logic [63:0] prod_q;
  logic        ready_q;
  logic [32:0] sum;

  assign sum = {1'b0, prod_q[63:32]} + (prod_q[0] ? {1'b0, mcand_q} : 33'd0);

  always_ff @(posedge clk) begin
    ready_q <= 1'b0;
    if (valid) begin
      mcand_q <= a;
      prod_q  <= {32'd0, b};
      cnt_q   <= 5'd0;
      run_q   <= 1'b1;
    end else if (run_q) begin
      prod_q <= {sum, prod_q[31:1]};
      cnt_q  <= cnt_q + 5'd1;
      if (cnt_q == 5'd31) begin
        run_q   <= 1'b0;
        ready_q <= 1'b1;
      end
    end
  end

  assign res   = prod_q;
  assign ready = ready_q;

endmodule

// File: rtl/mul_seq.sv
// rtl/mul_seq.sv - RISC-V MUL/MULH/MULHSU/MULHU sequencer around the unsigned mul32 core
module mul_seq
  import mul_seq_pkg::*;
#(
  parameter int DRAIN_CYCLES = 34
) (
  input  logic       clk,
  input  logic       reset,
  mul_seq_if.slave   bus
);

  localparam int CNT_W = $clog2(DRAIN_CYCLES);

  mul_state_e       state_q, state_d;
  logic [CNT_W-1:0] drain_cnt_q;
  logic [31:0]      a_abs_q, b_abs_q;
  mul_op_e          op_q;
  logic             neg_q;
  logic [63:0]      prod_q;
  logic [31:0]      res_q;

  logic             mul_valid;
  logic [63:0]      mul_res;
  logic             mul_ready;
  logic             busy_c, ready_c;
  logic             a_signed, b_signed;
  logic [63:0]      prod_fix;

  mul32 u_mul (
    .clk   (clk),
    .valid (mul_valid),
    .a     (a_abs_q),
    .b     (b_abs_q),
    .res   (mul_res),
    .ready (mul_ready)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_DRAIN;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_DRAIN: if (drain_cnt_q == CNT_W'(DRAIN_CYCLES - 1)) state_d = ST_IDLE;
      ST_IDLE:  if (bus.valid) state_d = ST_ISSUE;
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT:  if (mul_ready) state_d = ST_FIX;
      ST_FIX:   state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_DRAIN;
    endcase
  end

  always_comb begin
    busy_c    = (state_q != ST_IDLE);
    ready_c   = (state_q == ST_DONE);
    mul_valid = (state_q == ST_ISSUE);
  end

  assign a_signed = (bus.op == OP_MULH) || (bus.op == OP_MULHSU);
  assign b_signed = (bus.op == OP_MULH);
  assign prod_fix = neg_q ? (~prod_q + 64'd1) : prod_q;

  // Only WAIT listens to the core, so completions left over from before reset are dropped
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drain_cnt_q <= '0;
      a_abs_q     <= 32'd0;
      b_abs_q     <= 32'd0;
      op_q        <= OP_MUL;
      neg_q       <= 1'b0;
      prod_q      <= 64'd0;
      res_q       <= 32'd0;
    end else begin
      if (state_q == ST_DRAIN && state_d == ST_DRAIN) drain_cnt_q <= drain_cnt_q + 1'b1;
      if (state_q == ST_IDLE && bus.valid) begin
        a_abs_q <= abs32(bus.a, a_signed);
        b_abs_q <= abs32(bus.b, b_signed);
        op_q    <= bus.op;
        neg_q   <= (a_signed & bus.a[31]) ^ (b_signed & bus.b[31]);
      end
      if (state_q == ST_WAIT && mul_ready) prod_q <= mul_res;
      if (state_q == ST_FIX) res_q <= (op_q == OP_MUL) ? prod_fix[31:0] : prod_fix[63:32];
    end
  end

  assign bus.res   = res_q;
  assign bus.ready = ready_c;
  assign bus.busy  = busy_c;

endmodule
